// File: rtl/poly_horner_param.sv
// Horner-method polynomial evaluator: one multiply-add per clock, inicio/pronto/LED handshake.
// Optional build macro POLY_HORNER_SAT_EN: saturate overflowing steps to all-ones instead of wrapping.
module poly_horner_param #(
    parameter int WIDTH  = 16,
    parameter int DEGREE = 4,
    parameter int GW     = $clog2(DEGREE + 1)
) (
    input  logic                        ck,
    input  logic                        rst,
    input  logic                        inicio,
    input  logic                        pronto,
    input  logic [GW-1:0]               grau,
    input  logic [WIDTH-1:0]            X,
    input  logic [(DEGREE+1)*WIDTH-1:0] coef,
    output logic [WIDTH-1:0]            Resultado,
    output logic                        LED,
    output logic                        busy,
    output logic                        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FW = 2 * WIDTH + 1;

    state_t           state_r, state_nxt;
    logic [WIDTH-1:0] acc_r, acc_nxt;
    logic [GW-1:0]    idx_r, idx_nxt;
    logic             ovf_r, ovf_nxt;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] coef_r [0:DEGREE];
    logic [WIDTH-1:0] coef_in_s [0:DEGREE];
    logic [WIDTH-1:0] result_r, result_nxt;
    logic             led_r, led_nxt;
    logic             busy_r, busy_nxt;
    logic             load_s;
    logic [GW-1:0]    g_s;
    logic [GW-1:0]    idx_m1_s;
    logic [FW-1:0]    full_s;
    logic             step_ovf_s;
    logic [WIDTH-1:0] step_acc_s;

    // Unpack coefficients and compute one Horner step from the latched operands
    always_comb begin
        for (int i = 0; i <= DEGREE; i++) begin
            coef_in_s[i] = coef[i*WIDTH +: WIDTH];
        end
        g_s        = (grau > GW'(DEGREE)) ? GW'(DEGREE) : grau;
        idx_m1_s   = idx_r - GW'(1);
        full_s     = {{(WIDTH+1){1'b0}}, acc_r} * {{(WIDTH+1){1'b0}}, x_r}
                   + {{(WIDTH+1){1'b0}}, coef_r[idx_m1_s]};
        step_ovf_s = |full_s[FW-1:WIDTH];
`ifdef POLY_HORNER_SAT_EN
        step_acc_s = step_ovf_s ? {WIDTH{1'b1}} : full_s[WIDTH-1:0];
`else
        step_acc_s = full_s[WIDTH-1:0];
`endif
    end

    // Next-state and datapath update; outputs are precomputed so they can be registered
    always_comb begin
        state_nxt = state_r;
        acc_nxt   = acc_r;
        idx_nxt   = idx_r;
        ovf_nxt   = ovf_r;
        load_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (inicio) begin
                    load_s    = 1'b1;
                    acc_nxt   = coef_in_s[g_s];
                    idx_nxt   = g_s;
                    ovf_nxt   = 1'b0;
                    state_nxt = (g_s != GW'(0)) ? CALC : DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                acc_nxt = step_acc_s;
                ovf_nxt = ovf_r | step_ovf_s;
                idx_nxt = idx_m1_s;
                if (idx_m1_s == GW'(0)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CALC;
                end
            end
            DONE: begin
                if (pronto) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Result is captured only on entry to DONE, so it holds across IDLE and CALC
        result_nxt = ((state_nxt == DONE) && (state_r != DONE)) ? acc_nxt : result_r;
        led_nxt    = (state_nxt == DONE);
        busy_nxt   = (state_nxt != IDLE);
    end

    // State register
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Datapath, operand latches and registered outputs
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            acc_r    <= '0;
            idx_r    <= '0;
            ovf_r    <= 1'b0;
            x_r      <= '0;
            coef_r   <= '{default: '0};
            result_r <= '0;
            led_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            acc_r    <= acc_nxt;
            idx_r    <= idx_nxt;
            ovf_r    <= ovf_nxt;
            result_r <= result_nxt;
            led_r    <= led_nxt;
            busy_r   <= busy_nxt;
            if (load_s) begin
                x_r    <= X;
                coef_r <= coef_in_s;
            end
        end
    end

    assign Resultado = result_r;
    assign LED       = led_r;
    assign busy      = busy_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_poly_horner_param.sv
// Table-driven, scoreboarded bench for poly_horner_param (honours POLY_HORNER_SAT_EN).
module tb_poly_horner_param;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int GW = 3;
    localparam int CW = (D + 1) * W;

    typedef struct {
        logic [GW-1:0] grau;
        logic [W-1:0]  x;
        logic [CW-1:0] coef;
        logic [W-1:0]  res;
        logic          ovf;
        int            lat;
    } vec_t;

    logic          ck = 1'b0;
    logic          rst = 1'b0;
    logic          inicio = 1'b0;
    logic          pronto = 1'b0;
    logic [GW-1:0] grau = '0;
    logic [W-1:0]  X = '0;
    logic [CW-1:0] coef = '0;
    logic [W-1:0]  Resultado;
    logic          LED;
    logic          busy;
    logic          ovf;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t tbl [6];
    vec_t exp_q [$];

    poly_horner_param #(.WIDTH(W), .DEGREE(D)) dut (
        .ck(ck), .rst(rst), .inicio(inicio), .pronto(pronto), .grau(grau),
        .X(X), .coef(coef), .Resultado(Resultado), .LED(LED), .busy(busy), .ovf(ovf)
    );

    always #5 ck = ~ck;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer Horner evaluation with wrap or saturation
    function automatic vec_t model(input logic [GW-1:0] g_in, input logic [W-1:0] x, input logic [CW-1:0] c);
        vec_t   v;
        int     g;
        longint acc;
        g = (int'(g_in) > D) ? D : int'(g_in);
        acc = longint'(c[g*W +: W]);
        v.ovf = 1'b0;
        for (int i = g; i > 0; i--) begin
            acc = acc * longint'(x) + longint'(c[(i-1)*W +: W]);
            if (acc > 65535) begin
                v.ovf = 1'b1;
`ifdef POLY_HORNER_SAT_EN
                acc = 65535;
`else
                acc = acc & 65535;
`endif
            end
        end
        v.grau = g_in; v.x = x; v.coef = c;
        v.res = acc[W-1:0];
        v.lat = g + 1;
        return v;
    endfunction

    task automatic scramble();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        X = r[15:0];
        coef = r[CW-1:0];
        grau = r[GW+15:16];
    endtask

    // Start one evaluation, scramble inputs during CALC, then check and acknowledge
    task automatic run_vec(input vec_t v, input string nm);
        int   edges;
        logic got;
        vec_t e;
        @(negedge ck);
        grau = v.grau; X = v.x; coef = v.coef; inicio = 1'b1;
        exp_q.push_back(v);
        edges = 0; got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge ck);
            edges++;
            #1;
            inicio = 1'b0;
            scramble();
            @(negedge ck);
            if (LED) got = 1'b1;
            else check({nm, " busy in CALC"}, busy, 1);
        end
        check({nm, " LED seen"}, got, 1);
        check({nm, " latency"}, edges, v.lat);
        e = exp_q.pop_front();
        check({nm, " Resultado"}, Resultado, e.res);
        check({nm, " ovf"}, ovf, e.ovf);
        check({nm, " busy in DONE"}, busy, 1);
        pronto = 1'b1;
        @(posedge ck);
        #1 pronto = 1'b0;
        @(negedge ck);
        check({nm, " LED after ack"}, LED, 0);
        check({nm, " busy after ack"}, busy, 0);
        check({nm, " Resultado held"}, Resultado, e.res);
        check({nm, " ovf held"}, ovf, e.ovf);
    endtask

    initial begin
        int   hi;
        logic got;
        vec_t v;
        logic [95:0] r;

        tbl[0] = '{3'd2, 16'd3,     {16'd0, 16'd0, 16'd2, 16'd5, 16'd7},          16'h0028, 1'b0, 3};
        tbl[1] = '{3'd0, 16'd5,     {16'd9, 16'd9, 16'd9, 16'hFFFF, 16'h1234},    16'h1234, 1'b0, 1};
        tbl[2] = '{3'd7, 16'd2,     {16'd1, 16'd1, 16'd1, 16'd1, 16'd1},          16'h001F, 1'b0, 5};
        tbl[4] = '{3'd3, 16'd10,    {16'd0, 16'd1, 16'd2, 16'd3, 16'd4},          16'd1234, 1'b0, 4};
`ifdef POLY_HORNER_SAT_EN
        tbl[3] = '{3'd2, 16'h0100,  {16'd0, 16'd0, 16'd1, 16'd0, 16'd0},          16'hFFFF, 1'b1, 3};
        tbl[5] = '{3'd3, 16'h0100,  {16'd0, 16'd1, 16'd0, 16'd0, 16'd5},          16'hFFFF, 1'b1, 4};
`else
        tbl[3] = '{3'd2, 16'h0100,  {16'd0, 16'd0, 16'd1, 16'd0, 16'd0},          16'h0000, 1'b1, 3};
        tbl[5] = '{3'd3, 16'h0100,  {16'd0, 16'd1, 16'd0, 16'd0, 16'd5},          16'h0005, 1'b1, 4};
`endif

        // Reset state
        #12;
        check("reset Resultado", Resultado, 0);
        check("reset LED", LED, 0);
        check("reset busy", busy, 0);
        check("reset ovf", ovf, 0);
        @(negedge ck);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 6; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            v = model(3'($urandom_range(0, 7)), 16'($urandom_range(0, 20)), r[CW-1:0]);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // pronto already high on entry to DONE: LED lasts exactly one cycle
        @(negedge ck);
        grau = 3'd2; X = 16'd3; coef = {16'd0, 16'd0, 16'd2, 16'd5, 16'd7};
        inicio = 1'b1; pronto = 1'b1;
        @(posedge ck);
        #1 inicio = 1'b0;
        got = 1'b0; hi = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge ck);
            if (LED) begin
                hi++;
                if (!got) check("early pronto Resultado", Resultado, 40);
                got = 1'b1;
            end
        end
        check("early pronto LED cycles", hi, 1);
        check("early pronto busy", busy, 0);
        pronto = 1'b0;

        // inicio held high through CALC/DONE with pronto high: restart only from IDLE
        @(negedge ck);
        grau = 3'd1; X = 16'd3; coef = {16'd0, 16'd0, 16'd0, 16'd2, 16'd1};
        inicio = 1'b1; pronto = 1'b1;
        @(posedge ck); @(negedge ck);
        check("hold CALC busy", busy, 1);
        check("hold CALC LED", LED, 0);
        @(posedge ck); @(negedge ck);
        check("hold DONE LED", LED, 1);
        check("hold DONE Resultado", Resultado, 7);
        @(posedge ck); @(negedge ck);
        check("hold back to IDLE LED", LED, 0);
        check("hold back to IDLE busy", busy, 0);
        @(posedge ck);
        #1 inicio = 1'b0; pronto = 1'b0;
        @(negedge ck);
        check("hold restart busy", busy, 1);
        check("hold restart LED", LED, 0);
        @(posedge ck); @(negedge ck);
        check("hold restart DONE LED", LED, 1);
        check("hold restart Resultado", Resultado, 7);
        pronto = 1'b1;
        @(posedge ck);
        #1 pronto = 1'b0;

        // Asynchronous reset in the middle of a degree-4 evaluation
        @(negedge ck);
        grau = 3'd4; X = 16'h0100; coef = {16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        inicio = 1'b1;
        @(posedge ck);
        #1 inicio = 1'b0;
        @(posedge ck); @(posedge ck);
        #2 rst = 1'b0;
        #1;
        check("midreset Resultado", Resultado, 0);
        check("midreset LED", LED, 0);
        check("midreset busy", busy, 0);
        check("midreset ovf", ovf, 0);
        @(negedge ck);
        rst = 1'b1;
        run_vec(tbl[2], "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/poly_horner_param.md
Name: poly_horner_param

Overview:
- Parametrised successor of the team's fixed quadratic evaluator (Resultado = A·X² + B·X + C).
- Evaluates an unsigned polynomial of runtime-selectable degree 0..DEGREE in WIDTH-bit arithmetic using Horner's method, one multiply-add per clock.
- Keeps the inicio/pronto/LED handshake so it drops into the same top-level control flow.
- Adds an overflow flag, a busy indication and a held result.

Parameters:
- WIDTH, 16, operand, coefficient and result width in bits.
- DEGREE, 4, maximum supported polynomial degree.
- GW, $clog2(DEGREE+1), width of the grau input (derived; do not override).

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- inicio  input  1  start request; sampled only in IDLE.
- pronto  input  1  consumer acknowledge; sampled only in DONE.
- grau  input  GW  requested degree; latched at start.
- X  input  WIDTH  evaluation point; latched at start.
- coef  input  (DEGREE+1)*WIDTH  packed coefficients; coef[i*WIDTH +: WIDTH] is the coefficient of X^i; latched at start.
- Resultado  output  WIDTH  polynomial value.
- LED  output  1  result valid; high only in DONE.
- busy  output  1  high in CALC and DONE.
- ovf  output  1  sticky overflow for the current evaluation.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; Resultado=0, LED=0, busy=0, ovf=0; internal accumulator, index and latches cleared.
- Reset asserted mid-operation aborts immediately; no partial result is kept.
- States are IDLE, CALC and DONE.
- IDLE, edge with inicio=1:
  - Latch X and coef.
  - g = min(grau, DEGREE).
  - acc <= c[g], idx <= g, ovf <= 0.
  - Next state is CALC if g>0, else DONE.
- IDLE, inicio=0: remain in IDLE. Resultado holds its last value.
- CALC, each edge:
  - full = acc*X + c[idx-1], computed at 2*WIDTH+1 bits.
  - acc <= low WIDTH bits of full.
  - ovf <= ovf | (full >= 2^WIDTH).
  - idx <= idx-1.
  - When idx-1 == 0, go to DONE.
- Latency: LED rises g+1 edges after the edge that samples inicio.
- DONE:
  - Resultado = acc; LED=1; busy=1.
  - Edge with pronto=1 goes to IDLE; LED=0 and busy=0 from that edge.
  - Resultado and ovf hold until the next start.
- LED is high for at least one full cycle, even if pronto is already high on entry.
- inicio is ignored in CALC and DONE. A start needs inicio=1 sampled in IDLE, so inicio and pronto high together in DONE do not restart.
- pronto is ignored in IDLE and CALC.
- Latched operands are immune to input changes during CALC.
- grau values above DEGREE are clamped to DEGREE; no error is raised.
- Resultado is registered, with no combinational path from inputs.

Optional Feature:
- Macro: POLY_HORNER_SAT_EN.
- Defined: on an overflowing step, acc <= all-ones (2^WIDTH−1) and ovf is set. Subsequent steps continue from the saturated value, and overflow is again clamped.
- Undefined: results wrap modulo 2^WIDTH. ovf behaves the same in both builds.

Test Plan:
- Quadratic equivalence: WIDTH=16, grau=2, X=3, c0=7, c1=5, c2=2, inicio pulse → LED rises exactly 3 edges later, Resultado=0x0028 (40), ovf=0, busy=1 until pronto.
- Degree 0: grau=0, c0=0x1234 → LED rises 1 edge after start, Resultado=0x1234. Then pronto=1 for one cycle → LED=0 and busy=0 next edge, Resultado stays 0x1234.
- Clamp and full degree: grau=7 (above DEGREE=4), X=2, all coef=1 → latency 5 edges, Resultado=31 (0x001F).
- Overflow: grau=2, X=0x0100, c2=1, c1=0, c0=0 → wrap build gives Resultado=0x0000, ovf=1. POLY_HORNER_SAT_EN build gives Resultado=0xFFFF, ovf=1.
- Handshake robustness: pronto held high before DONE → LED high exactly one cycle. inicio held high through CALC/DONE with pronto=1 → no restart until the cycle after returning to IDLE. Changing X/coef during CALC does not alter the result.
- Reset mid-operation: rst=0 for 1 cycle during CALC of grau=4 → Resultado=0, LED=0, busy=0, ovf=0 immediately (asynchronous). A subsequent start computes correctly.
